// File: rtl/per_uart_tx.sv
// Transmit-only 8N1 UART slave on xSimBus: bus-written TX FIFO, baud generator, frame FSM.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module per_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  select_as_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        rw_in,
  output logic        tx_out
);

  localparam logic [1:0]  SELECT_AS_DEVICE = 2'b01;
  localparam logic        RW_INOUT_R       = 1'b0;
  localparam logic        RW_INOUT_W       = 1'b1;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam int          PTR_W            = $clog2(FIFO_DEPTH);
  localparam int          CNT_W            = PTR_W + 1;

  localparam logic [1:0]  REG_TXDATA  = 2'd0;
  localparam logic [1:0]  REG_STATUS  = 2'd1;
  localparam logic [1:0]  REG_BAUDDIV = 2'd2;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic [15:0]      baud_div_r;

  state_t           state_r;
  logic [7:0]       shift_r;
  logic [2:0]       bit_idx_r;
  logic [15:0]      baud_cnt_r;
  logic             parity_r;
  logic             tx_r;

  logic             wr_en_s;
  logic             rd_en_s;
  logic [1:0]       reg_sel_s;
  logic             push_req_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             busy_s;
  logic             baud_zero_s;
  logic [15:0]      reload_s;
  logic [7:0]       fifo_rd_data_s;
  logic [4:0]       count_ext_s;
  logic [31:0]      status_s;
  logic             unused_s;

  assign reg_sel_s      = addr_in[3:2];
  assign wr_en_s        = (select_as_in == SELECT_AS_DEVICE) && (rw_in == RW_INOUT_W);
  assign rd_en_s        = (select_as_in == SELECT_AS_DEVICE) && (rw_in == RW_INOUT_R);
  assign push_req_s     = wr_en_s && (reg_sel_s == REG_TXDATA);
  assign full_s         = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s        = (count_r == {CNT_W{1'b0}});
  assign push_s         = push_req_s && !full_s;
  assign busy_s         = (state_r != ST_IDLE);
  assign baud_zero_s    = (baud_cnt_r == 16'd0);
  // A divider of 0 behaves as 1 clock per bit.
  assign reload_s       = (baud_div_r == 16'd0) ? 16'd0 : (baud_div_r - 16'd1);
  assign fifo_rd_data_s = mem_r[rd_ptr_r];
  assign count_ext_s    = 5'(count_r);
  assign status_s       = {22'd0, PARITY_FLAG, count_ext_s, overflow_r, empty_s, full_s, busy_s};
  assign tx_out         = tx_r;
  assign unused_s       = ^{addr_in[31:4], addr_in[1:0], data_in[31:16]};

  // Pop decision: empty is the registered count, so a same-cycle push is seen next cycle.
  always_comb begin
    pop_s = 1'b0;
    if (!empty_s) begin
      case (state_r)
        ST_IDLE: pop_s = 1'b1;
        ST_STOP: pop_s = baud_zero_s;
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Bus read mux.
  always_comb begin
    data_out = ZERO_WORD;
    if (rd_en_s) begin
      case (reg_sel_s)
        REG_STATUS:  data_out = status_s;
        REG_BAUDDIV: data_out = {16'd0, baud_div_r};
        default:     data_out = ZERO_WORD;
      endcase
    end else begin
      data_out = ZERO_WORD;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_in[7:0];
    end
  end

  // FIFO pointers, count, sticky overflow and the baud divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      baud_div_r <= 16'(DEFAULT_DIV);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (push_req_s && full_s) begin
        overflow_r <= 1'b1;
      end else if (wr_en_s && (reg_sel_s == REG_STATUS) && data_in[3]) begin
        overflow_r <= 1'b0;
      end
      if (wr_en_s && (reg_sel_s == REG_BAUDDIV)) begin
        baud_div_r <= data_in[15:0];
      end
    end
  end

  // Frame FSM; the divider is sampled only at bit boundaries so a rewrite never stretches a bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'd0;
      bit_idx_r  <= 3'd0;
      baud_cnt_r <= 16'd0;
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            state_r    <= ST_START;
            shift_r    <= fifo_rd_data_s;
            parity_r   <= even_parity(fifo_rd_data_s);
            baud_cnt_r <= reload_s;
            tx_r       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_zero_s) begin
            state_r    <= ST_DATA;
            bit_idx_r  <= 3'd0;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[7:1]};
            baud_cnt_r <= reload_s;
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_zero_s) begin
            baud_cnt_r <= reload_s;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= ST_PARITY;
              tx_r    <= parity_r;
`else
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_zero_s) begin
            state_r    <= ST_STOP;
            tx_r       <= 1'b1;
            baud_cnt_r <= reload_s;
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_zero_s) begin
            if (pop_s) begin
              state_r    <= ST_START;
              shift_r    <= fifo_rd_data_s;
              parity_r   <= even_parity(fifo_rd_data_s);
              baud_cnt_r <= reload_s;
              tx_r       <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_per_uart_tx.sv
// Directed self-checking bench for per_uart_tx: register access, frame shapes,
// back-to-back frames, FIFO full/overflow and asynchronous reset mid-frame.
module tb_per_uart_tx;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_DEV  = 2'b01;
  localparam logic       RW_R     = 1'b0;
  localparam logic       RW_W     = 1'b1;

  localparam logic [31:0] A_TXDATA  = 32'h0000_0000;
  localparam logic [31:0] A_STATUS  = 32'h0000_0004;
  localparam logic [31:0] A_BAUDDIV = 32'h0000_0008;
  localparam logic [31:0] A_RSVD    = 32'h0000_000C;

`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PBIT = 32'h0000_0200;
`else
  localparam logic [31:0] PBIT = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  select_as_in = SEL_IDLE;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        rw_in = RW_R;
  logic        tx_out;

  int errors = 0;
  int checks = 0;

  per_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
    .clk          (clk),
    .rst          (rst),
    .select_as_in (select_as_in),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .rw_in        (rw_in),
    .tx_out       (tx_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    select_as_in = SEL_DEV;
    rw_in        = RW_W;
    addr_in      = a;
    data_in      = d;
    @(posedge clk);
    #1;
    select_as_in = SEL_IDLE;
    rw_in        = RW_R;
    data_in      = 32'd0;
  endtask

  task automatic bus_read_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    select_as_in = SEL_DEV;
    rw_in        = RW_R;
    addr_in      = a;
    #1;
    chk(tag, data_out, exp);
    select_as_in = SEL_IDLE;
  endtask

  // Samples tx_out and busy once per cycle; bits is LSB-first (bit 0 = first bit on the line).
  task automatic check_frame(input logic [31:0] bits, input int nbits, input int div, input string tag);
    select_as_in = SEL_DEV;
    rw_in        = RW_R;
    addr_in      = A_STATUS;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        chk({tag, "_tx"}, {31'd0, tx_out}, {31'd0, bits[b]});
        chk({tag, "_busy"}, {31'd0, data_out[0]}, 32'd1);
      end
    end
    @(negedge clk);
    chk({tag, "_idle_tx"}, {31'd0, tx_out}, 32'd1);
    chk({tag, "_idle_busy"}, {31'd0, data_out[0]}, 32'd0);
    select_as_in = SEL_IDLE;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_held", {31'd0, tx_out}, 32'd1);
    rst = 1'b1;
    bus_read_chk(A_STATUS, 32'h0000_0004 | PBIT, "rst_status");
    chk("rst_tx", {31'd0, tx_out}, 32'd1);
    bus_read_chk(A_BAUDDIV, 32'd434, "rst_bauddiv");
    bus_read_chk(A_TXDATA, 32'd0, "txdata_read_zero");
    bus_read_chk(A_RSVD, 32'd0, "rsvd_read_zero");

    // Not selected as device: data_out must stay zero
    @(negedge clk);
    select_as_in = SEL_IDLE;
    rw_in        = RW_R;
    addr_in      = A_BAUDDIV;
    #1;
    chk("unselected_read", data_out, 32'd0);

    // Writes to the reserved slot are ignored
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_read_chk(A_BAUDDIV, 32'd434, "rsvd_write_ignored");

    // Single frame 0xA5 at 4 clocks per bit
    bus_write(A_BAUDDIV, 32'd4);
    bus_read_chk(A_BAUDDIV, 32'd4, "bauddiv_rb");
    bus_write(A_TXDATA, 32'h0000_00A5);
    @(negedge clk);
    select_as_in = SEL_DEV;
    rw_in        = RW_R;
    addr_in      = A_STATUS;
    #1;
    chk("pre_pop_tx", {31'd0, tx_out}, 32'd1);
    chk("pre_pop_status", data_out, 32'h0000_0010 | PBIT);
`ifdef UART_TX_PARITY_EN
    check_frame({21'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, "a5");
`else
    check_frame({22'd0, 1'b1, 8'hA5, 1'b0}, 10, 4, "a5");
`endif
    bus_read_chk(A_STATUS, 32'h0000_0004 | PBIT, "a5_done_status");

    // Back-to-back frames: second start bit follows first stop bit directly
    bus_write(A_BAUDDIV, 32'd2);
    bus_write(A_TXDATA, 32'h0000_0055);
    bus_write(A_TXDATA, 32'h0000_000F);
`ifdef UART_TX_PARITY_EN
    check_frame({10'd0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 22, 2, "b2b");
`else
    check_frame({12'd0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}, 20, 2, "b2b");
`endif

    // Divider of 0 behaves as 1
    bus_write(A_BAUDDIV, 32'd0);
    bus_read_chk(A_BAUDDIV, 32'd0, "bauddiv_zero_rb");
    bus_write(A_TXDATA, 32'h0000_0001);
    @(negedge clk);
    chk("div0_pre_pop_tx", {31'd0, tx_out}, 32'd1);
`ifdef UART_TX_PARITY_EN
    check_frame({21'd0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 1, "div0");

    // Even parity of 0x07 is 1; frame is 11 cycles at divider 1
    bus_write(A_BAUDDIV, 32'd1);
    bus_write(A_TXDATA, 32'h0000_0007);
    @(negedge clk);
    chk("par_pre_pop_tx", {31'd0, tx_out}, 32'd1);
    check_frame(32'h0000_060E, 11, 1, "par07");
`else
    check_frame({22'd0, 1'b1, 8'h01, 1'b0}, 10, 1, "div0");
`endif

    // FIFO fill and overflow while the first byte is on the line
    bus_write(A_BAUDDIV, 32'd100);
    for (int i = 0; i < 9; i++) begin
      bus_write(A_TXDATA, 32'h0000_0000);
    end
    bus_read_chk(A_STATUS, 32'h0000_0083 | PBIT, "full_status");
    bus_write(A_TXDATA, 32'h0000_0000);
    bus_read_chk(A_STATUS, 32'h0000_008B | PBIT, "overflow_status");
    bus_write(A_STATUS, 32'h0000_0008);
    bus_read_chk(A_STATUS, 32'h0000_0083 | PBIT, "overflow_cleared");

    // Reset in the middle of a data bit
    repeat (120) @(negedge clk);
    chk("mid_data_tx", {31'd0, tx_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, tx_out}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus_read_chk(A_STATUS, 32'h0000_0004 | PBIT, "post_rst_status");
    bus_read_chk(A_BAUDDIV, 32'd434, "post_rst_bauddiv");
    repeat (30) @(negedge clk);
    chk("post_rst_idle_tx", {31'd0, tx_out}, 32'd1);
    bus_read_chk(A_STATUS, 32'h0000_0004 | PBIT, "post_rst_fifo_discarded");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
